wb_arb2: RTL and testbench

Two-master Wishbone arbiter that shares one slave port (typically the external SRAM controller) between two bus masters, e.g. the LM32 instruction and data ports. It sits between the masters and the slave. It grants the bus round-robin per Wishbone cycle and holds the grant for the whole `cyc` envelope, so LM32 bursts are not split. An optional watchdog terminates stalled slave accesses with `err`.

---
 rtl/wb_arb2.sv | 145 ++++++++++++++
 tb/tb_wb_arb2.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter: round-robin per cyc envelope, grant held until the owner drops cyc.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb2 #(
    parameter int adr_width      = 32,
    parameter int timeout_cycles = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [adr_width-1:0] m0_adr_i,
    input  logic [31:0]          m0_dat_i,
    input  logic [3:0]           m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic [31:0]          m0_dat_o,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,
    input  logic [adr_width-1:0] m1_adr_i,
    input  logic [31:0]          m1_dat_i,
    input  logic [3:0]           m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic [31:0]          m1_dat_o,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,
    output logic [adr_width-1:0] s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    output logic [1:0]           gnt_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    if (timeout_cycles < 1 || timeout_cycles > 255) begin : g_bad_timeout
        $error("wb_arb2: timeout_cycles must be within 1..255");
    end

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       last;
    logic       last_nxt;
    logic       gnt0;
    logic       gnt1;
    logic       wd_err;

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    // tie goes to whoever did not own the bus last
                    state_nxt = last ? GNT0 : GNT1;
                    last_nxt  = ~last;
                end else if (m0_cyc_i) begin
                    state_nxt = GNT0;
                    last_nxt  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nxt = GNT1;
                    last_nxt  = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    if (m1_cyc_i) begin
                        state_nxt = GNT1;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    if (m0_cyc_i) begin
                        state_nxt = GNT0;
                        last_nxt  = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    assign gnt0  = (state == GNT0);
    assign gnt1  = (state == GNT1);
    assign gnt_o = {gnt1, gnt0};

    // IDLE falls through to m0 for the data path; cyc/stb are gated by the grant
    assign s_adr_o = gnt1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = gnt1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o = gnt1 ? m1_sel_i : m0_sel_i;
    assign s_we_o  = gnt1 ? m1_we_i  : m0_we_i;
    assign s_cyc_o = (gnt0 & m0_cyc_i) | (gnt1 & m1_cyc_i);
    assign s_stb_o = (gnt0 & m0_cyc_i & m0_stb_i) | (gnt1 & m1_cyc_i & m1_stb_i);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // a response arriving after the owner has dropped cyc belongs to no one
    assign m0_ack_o = gnt0 & m0_cyc_i & s_ack_i;
    assign m1_ack_o = gnt1 & m1_cyc_i & s_ack_i;
    assign m0_err_o = gnt0 & m0_cyc_i & (s_err_i | wd_err);
    assign m1_err_o = gnt1 & m1_cyc_i & (s_err_i | wd_err);

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;

    assign wd_err = s_stb_o && !s_ack_i && !s_err_i && (wd_cnt == 8'(timeout_cycles));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= 8'd0;
        end else if (!s_stb_o || s_ack_i || s_err_i || wd_err) begin
            wd_cnt <= 8'd0;
        end else begin
            wd_cnt <= wd_cnt + 8'd1;
        end
    end
`else
    assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: single read, round-robin handover, burst hold, ack routing, watchdog, async reset.
module tb_wb_arb2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_cyc_o, s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  gnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_arb2 #(.adr_width(32), .timeout_cycles(8)) dut (
        .clk(clk), .reset(reset),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .gnt_o(gnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_adr_i = 32'h0000_0100; m0_dat_i = 32'h1111_1111; m0_sel_i = 4'hF; m0_we_i = 1'b0;
        m1_adr_i = 32'h0000_0200; m1_dat_i = 32'h2222_2222; m1_sel_i = 4'h3; m1_we_i = 1'b1;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = 32'h0; s_ack_i = 1'b0; s_err_i = 1'b0;

        // reset state
        #2;
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_cyc", 32'(s_cyc_o), 32'h0);
        check("rst_stb", 32'(s_stb_o), 32'h0);
        check("rst_ack", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'h0);
        tick();
        reset = 1'b0;

        // m0 single read
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        #1;
        check("rd_gnt_wait", 32'(gnt_o), 32'h0);
        check("rd_stb_wait", 32'(s_stb_o), 32'h0);
        tick();
        check("rd_gnt", 32'(gnt_o), 32'h1);
        check("rd_stb", 32'(s_stb_o), 32'h1);
        check("rd_adr", s_adr_o, 32'h0000_0100);
        check("rd_sel", 32'(s_sel_o), 32'hF);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        #1;
        check("rd_ack", 32'(m0_ack_o), 32'h1);
        check("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("rd_m1_dat", m1_dat_o, 32'hDEAD_BEEF);
        check("rd_m1_ack", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        check("rd_ack_off", 32'(m0_ack_o), 32'h0);
        check("rd_cyc_off", 32'(s_cyc_o), 32'h0);
        tick();
        check("rd_gnt_idle", 32'(gnt_o), 32'h0);

        // fresh reset, then simultaneous requests held continuously
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                if (c == 0 && k > 0) begin
                    if (k % 2 == 1) begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
                    else begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
                end
                if (c == 3) begin
                    if (k % 2 == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
                    else begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
                end
                #1;
                check($sformatf("rr_gnt_%0d_%0d", k, c), 32'(gnt_o), (k % 2 == 0) ? 32'h1 : 32'h2);
                if (c == 3) check($sformatf("rr_handover_cyc_%0d", k), 32'(s_cyc_o), 32'h0);
            end
        end
        tick();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        tick();
        check("rr_idle", 32'(gnt_o), 32'h0);

        // m1 burst with stb gaps while m0 waits
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
            m1_stb_i = (i % 2 == 0);
            s_ack_i  = (i % 2 == 0);
            #1;
            check($sformatf("bu_gnt_%0d", i), 32'(gnt_o), 32'h2);
            check($sformatf("bu_m0ack_%0d", i), 32'(m0_ack_o), 32'h0);
            check($sformatf("bu_m1ack_%0d", i), 32'(m1_ack_o), (i % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("bu_stb_%0d", i), 32'(s_stb_o), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        tick();
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
        #1;
        check("bu_gnt_end", 32'(gnt_o), 32'h2);
        check("bu_cyc_end", 32'(s_cyc_o), 32'h0);
        tick();
        check("bu_handover", 32'(gnt_o), 32'h1);

        // ack/err routing while m1 owns and m0 keeps requesting
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
        #1;
        check("rt_gnt", 32'(gnt_o), 32'h2);
        check("rt_m1ack", 32'(m1_ack_o), 32'h1);
        check("rt_m0ack", 32'(m0_ack_o), 32'h0);
        check("rt_adr", s_adr_o, 32'h0000_0200);
        check("rt_we", 32'(s_we_o), 32'h1);
        s_ack_i = 1'b0; s_err_i = 1'b1;
        #1;
        check("rt_m1err", 32'(m1_err_o), 32'h1);
        check("rt_m0err", 32'(m0_err_o), 32'h0);
        tick();
        s_err_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b1;
        #1;
        check("rt_late_ack", 32'(m1_ack_o), 32'h0);
        s_ack_i = 1'b0;

        // m0 owns, slave never answers
`ifdef WB_ARB_TIMEOUT_EN
        for (int t = 0; t < 20; t++) begin
            tick();
            if (t == 0) check("wd_stb_first", 32'(s_stb_o), 32'h1);
            check($sformatf("wd_err_%0d", t), 32'(m0_err_o), (t == 8 || t == 17) ? 32'h1 : 32'h0);
        end
`else
        for (int t = 0; t < 1000; t++) begin
            tick();
            if (t == 0) check("wd_stb_first", 32'(s_stb_o), 32'h1);
            check($sformatf("wd_noerr_%0d", t), 32'(m0_err_o), 32'h0);
        end
`endif
        check("wd_gnt", 32'(gnt_o), 32'h1);

        // asynchronous reset during m0 wait state
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("ar_cyc", 32'(s_cyc_o), 32'h0);
        check("ar_stb", 32'(s_stb_o), 32'h0);
        check("ar_gnt", 32'(gnt_o), 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
